// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port core memory bank with a registered read address.
// It also runs a clear sequencer that writes zero to every word of the bank.
module mem_arbiter #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic                  clr,
  output logic                  clr_busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_ACK,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state_q;
  logic                    last_grant_q;  // 1 = port B held the most recent grant
  logic                    a_ack_q;
  logic                    b_ack_q;
  logic                    clr_busy_q;
  logic                    ram_we_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [DATA_WIDTH-1:0]   ram_data_q;
  logic [DATA_WIDTH-1:0]   a_rdata_q;
  logic [DATA_WIDTH-1:0]   b_rdata_q;
  logic                    grant_b_d;

  // On a tie, the port that did not hold the last grant wins.
  always_comb begin
    grant_b_d = b_req;
    if (a_req && b_req) begin
      grant_b_d = !last_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      clr_busy_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b1;
            clr_busy_q <= 1'b1;
            state_q    <= S_CLEAR;
          end else if (a_req || b_req) begin
            last_grant_q <= grant_b_d;
            ram_addr_q   <= grant_b_d ? b_addr  : a_addr;
            ram_data_q   <= grant_b_d ? b_wdata : a_wdata;
            ram_we_q     <= grant_b_d ? b_wr    : a_wr;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          ram_we_q <= 1'b0;
          state_q  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // The memory returns the new word on a write, so reads and writes share this path.
          if (last_grant_q) begin
            b_rdata_q <= ram_q;
            b_ack_q   <= 1'b1;
          end else begin
            a_rdata_q <= ram_q;
            a_ack_q   <= 1'b1;
          end
          state_q <= S_ACK;
        end
        S_ACK: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_CLEAR: begin
          ram_addr_q <= ram_addr_q + 1'b1;
          if (ram_addr_q == LAST_ADDR) begin
            ram_we_q   <= 1'b0;
            clr_busy_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign clr_busy = clr_busy_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port on-chip core memory bank (36-bit words, 2^ADDR_WIDTH deep, registered read address) between two requesters: port A (processor memory bus) and port B (console/loader).
- Sequences each access through the memory's write/read-address timing and returns data with a one-cycle acknowledge.
- Provides a memory-clear sequencer that zeroes the whole bank on command.
- Sits between the bus interfaces and the memory instance.

Parameters:
DATA_WIDTH, 36, memory word width
ADDR_WIDTH, 14, memory address width; depth = 2^ADDR_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
a_req  input  1  port A request, held until a_ack seen
a_wr  input  1  port A: 1 = write, 0 = read; stable while a_req
a_addr  input  ADDR_WIDTH  port A address
a_wdata  input  DATA_WIDTH  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_rdata  output  DATA_WIDTH  port A read data, valid while a_ack high and held until next A completion
b_req, b_wr, b_addr, b_wdata  input  1/1/ADDR_WIDTH/DATA_WIDTH  port B equivalents
b_ack, b_rdata  output  1/DATA_WIDTH  port B equivalents
clr  input  1  start memory clear (sampled in IDLE only)
clr_busy  output  1  high while clear in progress
ram_addr  output  ADDR_WIDTH  to memory address, registered
ram_data  output  DATA_WIDTH  to memory write data, registered
ram_we  output  1  to memory write enable, registered
ram_q  input  DATA_WIDTH  from memory read data; reflects address presented one clock earlier, new data on write

Behaviour:
- Reset (reset_n low at a rising edge): state IDLE; all outputs 0; last_grant = B, so A wins the first tie.
- Reset mid-access abandons the access with no ack. A write already clocked into memory stays written. A clear stops at its current address.
- States: IDLE, ACCESS, CAPTURE, ACK, CLEAR.
- IDLE:
  - If clr is high: ram_addr <= 0, ram_data <= 0, ram_we <= 1, clr_busy <= 1, go CLEAR. clr has priority over a_req and b_req.
  - Else if any req: choose the grant, then register ram_addr <= x_addr, ram_data <= x_wdata, ram_we <= x_wr, latch grant, go ACCESS.
  - Grant rule: only one port requesting wins. Both requesting: the port not equal to last_grant wins (round-robin). last_grant updates on grant.
- ACCESS: memory samples addr/we at the closing edge. ram_we <= 0; go CAPTURE.
- CAPTURE: ram_q is valid. Granted port's rdata <= ram_q, ack <= 1; go ACK.
  - A write returns the newly written word in rdata.
- ACK: ack high exactly this cycle, cleared at the closing edge; go IDLE.
  - Requester drops req at the edge where it sees ack.
  - A req still high in the following IDLE cycle is a new access.
- Latency: req first seen high in IDLE cycle n -> ack high in cycle n+3. One access per 4 cycles minimum per arbiter.
- CLEAR:
  - One write of zero per cycle: ram_addr increments by 1 each cycle with ram_we = 1.
  - When ram_addr = 2^ADDR_WIDTH-1 is presented: next edge sets ram_we <= 0, clr_busy <= 0, go IDLE. The address wraps to 0 internally; the counter must not overflow into extra writes.
  - clr_busy is high for exactly 2^ADDR_WIDTH cycles.
  - Requests during CLEAR are held off (no ack). They are arbitrated in the first IDLE cycle after.
  - clr asserted outside IDLE is ignored. clr held high after clear completes starts another clear.
- The unserved port's req is never dropped or lost. Its ack only ever pulses for its own access.
- rdata registers hold their value except on their own port's CAPTURE.

Test Plan:
- Read A: preload mem[0o1234] = 0o123456701234; a_req, a_wr=0, a_addr=0o1234 at cycle 0 -> a_ack high only in cycle 3, a_rdata = 0o123456701234, b_ack stays 0.
- Write-then-read B: b write 0o777777000001 to 0o100 -> b_ack at cycle 3 with b_rdata = 0o777777000001. A following b read of 0o100 returns the same value; mem[0o100] checked by model.
- Contention: a_req and b_req both held continuously after reset -> grants alternate A, B, A, B. Each ack exactly 4 cycles apart, no port starved.
- Clear with ADDR_WIDTH=4, memory prefilled nonzero: pulse clr in IDLE -> clr_busy high exactly 16 cycles, ram_we high 16 cycles, addresses 0..15 each written once, all words read back 0.
- Request during clear: a_req asserted at clear cycle 5 -> no a_ack until after clr_busy falls. Then a_ack 3 cycles after the first IDLE cycle, and read data = 0.
- Reset mid-access: reset_n low during CAPTURE -> next cycle all outputs 0, no ack ever issued for that access. After release, a held a_req is served normally.
